// File: rtl/ln_fetch_intf.sv
// Parameter-word write port from ln_param_fetch into the layer-norm
// gamma/beta register file.
interface ln_fetch_intf #(
    parameter int DATA_W = 1408
);
    logic [DATA_W-1:0] data;
    logic              gamma_low_we;
    logic              gamma_high_we;
    logic              beta_we;

    modport fetch (output data, gamma_low_we, gamma_high_we, beta_we);
    modport sink  (input  data, gamma_low_we, gamma_high_we, beta_we);
endinterface

// File: rtl/ln_param_fetch.sv
// Fetches up to three layer-norm parameter words (gamma_low, gamma_high, beta)
// from consecutive memory words and strobes each into the consumer.
module ln_param_fetch #(
    parameter int DATA_W = 1408,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [2:0]        load_mask,
    output logic              busy,
    output logic              done,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic [DATA_W-1:0] mem_rdata,
    ln_fetch_intf.fetch       ln
);
    typedef enum logic [2:0] {IDLE, RD_GL, RD_GH, RD_B, DRAIN} state_e;
    typedef enum logic [1:0] {TAG_GL, TAG_GH, TAG_B} tag_e;
    typedef struct packed {
        logic vld;
        tag_e tag;
    } ret_t;

    state_e            state, nxt_state;
    logic [ADDR_W-1:0] base_q, nxt_base;
    logic [2:0]        mask_q;
    ret_t              ret_q;
    logic              accept, grant;

    function automatic state_e first_rd(input logic [2:0] m);
        if (m[0])      return RD_GL;
        else if (m[1]) return RD_GH;
        else if (m[2]) return RD_B;
        else           return DRAIN;
    endfunction

    function automatic logic is_rd(input state_e s);
        return (s == RD_GL) || (s == RD_GH) || (s == RD_B);
    endfunction

    function automatic logic [ADDR_W-1:0] rd_addr(input state_e s, input logic [ADDR_W-1:0] b);
        case (s)
            RD_GH:   return b + ADDR_W'(1);
            RD_B:    return b + ADDR_W'(2);
            default: return b;
        endcase
    endfunction

    function automatic tag_e tag_of(input state_e s);
        case (s)
            RD_GH:   return TAG_GH;
            RD_B:    return TAG_B;
            default: return TAG_GL;
        endcase
    endfunction

    // busy is still high on the done cycle, which blocks a same-cycle restart
    assign accept = (state == IDLE) && start && !busy;
    assign grant  = mem_re && mem_gnt;

    always_comb begin
        nxt_state = state;
        nxt_base  = base_q;
        case (state)
            IDLE: if (accept) begin
                nxt_state = first_rd(load_mask);
                nxt_base  = base_addr;
            end
            RD_GL: if (grant) nxt_state = first_rd(mask_q & 3'b110);
            RD_GH: if (grant) nxt_state = first_rd(mask_q & 3'b100);
            RD_B:  if (grant) nxt_state = DRAIN;
            // No reads issue from DRAIN, so the one return that can still be
            // in flight lands on the same cycle the registered done rises.
            DRAIN: nxt_state = IDLE;
            default: nxt_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            base_q           <= '0;
            mask_q           <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            mem_re           <= 1'b0;
            mem_addr         <= '0;
            ret_q            <= '{vld: 1'b0, tag: TAG_GL};
            ln.data          <= '0;
            ln.gamma_low_we  <= 1'b0;
            ln.gamma_high_we <= 1'b0;
            ln.beta_we       <= 1'b0;
        end else begin
            state  <= nxt_state;
            base_q <= nxt_base;
            if (accept) mask_q <= load_mask;

            busy <= (nxt_state != IDLE) || (state == DRAIN);
            done <= (state == DRAIN);

            mem_re <= is_rd(nxt_state);
            if (is_rd(nxt_state)) mem_addr <= rd_addr(nxt_state, nxt_base);

            ret_q <= '{vld: grant, tag: tag_of(state)};

            ln.gamma_low_we  <= ret_q.vld && (ret_q.tag == TAG_GL);
            ln.gamma_high_we <= ret_q.vld && (ret_q.tag == TAG_GH);
            ln.beta_we       <= ret_q.vld && (ret_q.tag == TAG_B);
            if (ret_q.vld) ln.data <= mem_rdata;
        end
    end
endmodule

// File: tb/tb_ln_param_fetch.sv
// Directed bench for ln_param_fetch: cycle-by-cycle expected tables per scenario.
module tb_ln_param_fetch;
    localparam int DW = 1408;
    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [2:0]    load_mask = '0;
    logic          busy, done, mem_re;
    logic [AW-1:0] mem_addr;
    logic          mem_gnt = 1'b0;
    logic [DW-1:0] mem_rdata = '0;

    ln_fetch_intf #(.DATA_W(DW)) lnif ();

    ln_param_fetch #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .load_mask(load_mask), .busy(busy), .done(done), .mem_re(mem_re),
        .mem_addr(mem_addr), .mem_gnt(mem_gnt), .mem_rdata(mem_rdata), .ln(lnif)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        return {88{a ^ 16'h5A3C}};
    endfunction

    // memory: data one cycle after the grant, junk otherwise
    always @(posedge clk)
        mem_rdata <= (mem_re && mem_gnt) ? pat(mem_addr) : {88{16'hDEAD}};

    // {busy, done, mem_re, gamma_low_we, gamma_high_we, beta_we}
    logic [5:0] flags;
    assign flags = {busy, done, mem_re, lnif.gamma_low_we, lnif.gamma_high_we, lnif.beta_we};

    int checks = 0;
    int failures = 0;
    logic [DW-1:0] exp_d = '0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if (flags !== 6'b0) begin failures++; $display("FAIL reset_flags got=%b exp=000000", flags); end
        checks++;
        if (mem_addr !== '0) begin failures++; $display("FAIL reset_addr got=%h exp=0000", mem_addr); end
        checks++;
        if (lnif.data !== '0) begin failures++; $display("FAIL reset_data got=%h exp=0", lnif.data[31:0]); end
        rst = 1'b0;
        exp_d = '0;
    endtask

    task automatic test_full_load(input logic [AW-1:0] b, input string nm);
        logic [5:0] ef [6] = '{6'b101000, 6'b101000, 6'b101100, 6'b100010, 6'b110001, 6'b000000};
        int ao [6] = '{0, 1, 2, -1, -1, -1};
        int dof [6] = '{-1, -1, 0, 1, 2, -1};
        int busy_n = 0;
        base_addr = b; load_mask = 3'b111; start = 1'b1; mem_gnt = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            start = 1'b0;
            if (busy) busy_n++;
            checks++;
            if (flags !== ef[i]) begin failures++; $display("FAIL %s_flags c%0d got=%b exp=%b", nm, i, flags, ef[i]); end
            if (ao[i] >= 0) begin
                checks++;
                if (mem_addr !== AW'(b + ao[i])) begin failures++; $display("FAIL %s_addr c%0d got=%h exp=%h", nm, i, mem_addr, AW'(b + ao[i])); end
            end
            if (dof[i] >= 0) exp_d = pat(AW'(b + dof[i]));
            checks++;
            if (lnif.data !== exp_d) begin failures++; $display("FAIL %s_data c%0d got=%h exp=%h", nm, i, lnif.data[31:0], exp_d[31:0]); end
        end
        checks++;
        if (busy_n !== 5) begin failures++; $display("FAIL %s_busy_len got=%0d exp=5", nm, busy_n); end
    endtask

    task automatic test_partial();
        logic [AW-1:0] b = 16'h0100;
        logic [5:0] ef [4] = '{6'b101000, 6'b100000, 6'b110001, 6'b000000};
        int ao [4] = '{2, -1, -1, -1};
        int dof [4] = '{-1, -1, 2, -1};
        base_addr = b; load_mask = 3'b100; start = 1'b1; mem_gnt = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            start = 1'b0;
            checks++;
            if (flags !== ef[i]) begin failures++; $display("FAIL partial_flags c%0d got=%b exp=%b", i, flags, ef[i]); end
            if (ao[i] >= 0) begin
                checks++;
                if (mem_addr !== AW'(b + ao[i])) begin failures++; $display("FAIL partial_addr c%0d got=%h exp=%h", i, mem_addr, AW'(b + ao[i])); end
            end
            if (dof[i] >= 0) exp_d = pat(AW'(b + dof[i]));
            checks++;
            if (lnif.data !== exp_d) begin failures++; $display("FAIL partial_data c%0d got=%h exp=%h", i, lnif.data[31:0], exp_d[31:0]); end
        end
    endtask

    task automatic test_backpressure();
        logic [AW-1:0] b = 16'h0020;
        logic [5:0] ef [9] = '{6'b101000, 6'b101000, 6'b101100, 6'b101000, 6'b101000,
                               6'b101000, 6'b100010, 6'b110001, 6'b000000};
        int ao [9]  = '{0, 1, 1, 1, 1, 2, -1, -1, -1};
        int dof [9] = '{-1, -1, 0, -1, -1, -1, 1, 2, -1};
        logic gt [9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        base_addr = b; load_mask = 3'b111; start = 1'b1;
        for (int i = 0; i < 9; i++) begin
            step();
            start = 1'b0;
            mem_gnt = gt[i];
            checks++;
            if (flags !== ef[i]) begin failures++; $display("FAIL bp_flags c%0d got=%b exp=%b", i, flags, ef[i]); end
            if (ao[i] >= 0) begin
                checks++;
                if (mem_addr !== AW'(b + ao[i])) begin failures++; $display("FAIL bp_addr c%0d got=%h exp=%h", i, mem_addr, AW'(b + ao[i])); end
            end
            if (dof[i] >= 0) exp_d = pat(AW'(b + dof[i]));
            checks++;
            if (lnif.data !== exp_d) begin failures++; $display("FAIL bp_data c%0d got=%h exp=%h", i, lnif.data[31:0], exp_d[31:0]); end
        end
        mem_gnt = 1'b1;
    endtask

    task automatic test_empty();
        logic [5:0] ef [4] = '{6'b100000, 6'b110000, 6'b000000, 6'b000000};
        base_addr = 16'h0200; load_mask = 3'b000; start = 1'b1; mem_gnt = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            // start held on the done cycle must be dropped
            start = (i == 1);
            if (i == 1) begin base_addr = 16'h0050; load_mask = 3'b111; end
            checks++;
            if (flags !== ef[i]) begin failures++; $display("FAIL empty_flags c%0d got=%b exp=%b", i, flags, ef[i]); end
            checks++;
            if (lnif.data !== exp_d) begin failures++; $display("FAIL empty_data c%0d got=%h exp=%h", i, lnif.data[31:0], exp_d[31:0]); end
        end
        start = 1'b0;
    endtask

    task automatic test_reset_midload();
        logic [AW-1:0] b = 16'h0030;
        logic [5:0] ef [5] = '{6'b101000, 6'b101000, 6'b000000, 6'b000000, 6'b000000};
        base_addr = b; load_mask = 3'b111; start = 1'b1; mem_gnt = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            start = 1'b0;
            rst = (i == 1);
            if (i >= 2) exp_d = '0;
            checks++;
            if (flags !== ef[i]) begin failures++; $display("FAIL rstmid_flags c%0d got=%b exp=%b", i, flags, ef[i]); end
            checks++;
            if (mem_addr !== ((i < 2) ? AW'(b + i) : AW'(0))) begin
                failures++; $display("FAIL rstmid_addr c%0d got=%h", i, mem_addr);
            end
            checks++;
            if (lnif.data !== exp_d) begin failures++; $display("FAIL rstmid_data c%0d got=%h exp=%h", i, lnif.data[31:0], exp_d[31:0]); end
        end
    endtask

    task automatic test_start_busy();
        logic [AW-1:0] b = 16'h0040;
        logic [5:0] ef [7] = '{6'b101000, 6'b101000, 6'b101100, 6'b100010, 6'b110001, 6'b000000, 6'b000000};
        int ao [7]  = '{0, 1, 2, -1, -1, -1, -1};
        int dof [7] = '{-1, -1, 0, 1, 2, -1, -1};
        base_addr = b; load_mask = 3'b111; start = 1'b1; mem_gnt = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step();
            start = (i == 1);
            if (i == 1) begin base_addr = 16'h0080; load_mask = 3'b001; end
            checks++;
            if (flags !== ef[i]) begin failures++; $display("FAIL busystart_flags c%0d got=%b exp=%b", i, flags, ef[i]); end
            if (ao[i] >= 0) begin
                checks++;
                if (mem_addr !== AW'(b + ao[i])) begin failures++; $display("FAIL busystart_addr c%0d got=%h exp=%h", i, mem_addr, AW'(b + ao[i])); end
            end
            if (dof[i] >= 0) exp_d = pat(AW'(b + dof[i]));
            checks++;
            if (lnif.data !== exp_d) begin failures++; $display("FAIL busystart_data c%0d got=%h exp=%h", i, lnif.data[31:0], exp_d[31:0]); end
        end
        start = 1'b0;
    endtask

    initial begin
        test_reset();
        test_full_load(16'h0010, "full");
        test_partial();
        test_backpressure();
        test_full_load(16'hFFFF, "wrap");
        test_empty();
        test_reset_midload();
        test_start_busy();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ln_param_fetch.md
LN_PARAM_FETCH -- requirements
Module: ln_param_fetch

Interface
REQ-001 SHALL have parameter DATA_W, default 1408 (176*8), meaning the width of one parameter word and of the ln_fetch_intf data bus.
REQ-002 SHALL have parameter ADDR_W, default 16, meaning the parameter-memory word address width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: the reset, which is synchronous and active-high.
REQ-005 SHALL have port start, input, 1 bit: a load request, accepted only in IDLE.
REQ-006 SHALL have port base_addr, input, ADDR_W bits: the word address of gamma_low, sampled on the accept cycle.
REQ-007 SHALL have port load_mask, input, 3 bits: which words to load (bit0 gamma_low, bit1 gamma_high, bit2 beta), sampled on the accept cycle.
REQ-008 SHALL have port busy, output, 1 bit: a load is in progress.
REQ-009 SHALL have port done, output, 1 bit: a one-cycle completion pulse.
REQ-010 SHALL have port mem_re, output, 1 bit: the memory read request.
REQ-011 SHALL have port mem_addr, output, ADDR_W bits: the read address.
REQ-012 SHALL have port mem_gnt, input, 1 bit: the request is accepted in a cycle where mem_re and mem_gnt are both high.
REQ-013 SHALL have port mem_rdata, input, DATA_W bits: the read data, valid exactly one cycle after the grant cycle.
REQ-014 SHALL have port ln, an ln_fetch_intf.fetch modport, driving data, gamma_low_we, gamma_high_we and beta_we.

Function
REQ-015 SHALL implement the FSM states IDLE, RD_GL, RD_GH, RD_B and DRAIN.
REQ-016 On start in IDLE, SHALL latch base_addr and load_mask, raise busy the next cycle, and go to the first state whose mask bit is set, in the order GL, GH, B.
REQ-017 If load_mask==0, SHALL go to DRAIN with no memory reads.
REQ-018 In RD_GL, RD_GH and RD_B, SHALL hold mem_re=1 with mem_addr = base+0, +1 or +2 respectively, until granted.
REQ-019 On grant, SHALL advance to the next masked read state, or to DRAIN if none remains.
REQ-020 All address arithmetic SHALL be modulo 2^ADDR_W (wrap-around).
REQ-021 SHALL keep mem_re=0 in IDLE and DRAIN.
REQ-022 SHALL record a per-grant tag (GL/GH/B) in a 1-deep return pipeline.
REQ-023 For a read granted in cycle t, SHALL register mem_rdata from cycle t+1 onto ln.data in cycle t+2, together with exactly the tagged *_we for that one cycle.
REQ-024 At most one of the *_we strobes SHALL be high in any cycle.
REQ-025 ln.data SHALL hold its last value while all *_we strobes are low.
REQ-026 Back-to-back grants SHALL produce *_we strobes in consecutive cycles.
REQ-027 DRAIN SHALL wait until no return is pending and no *_we is outstanding, then pulse done for one cycle and return to IDLE.
REQ-028 done SHALL coincide with, or follow, the final *_we strobe; with a full mask and continuous grants, done SHALL coincide with beta_we.
REQ-029 For load_mask==0, done SHALL pulse exactly one cycle after busy rises.
REQ-030 busy SHALL be high from the cycle after accept through the done cycle inclusive, and low otherwise.
REQ-031 start while busy SHALL be ignored and not queued; start on the same cycle as done SHALL be ignored.

Reset
REQ-032 While rst is high, SHALL force state=IDLE, busy=0, done=0, mem_re=0, mem_addr=0, ln.data=0, all *_we=0, the return pipeline empty, and the latched base/mask=0.
REQ-033 Reset mid-load SHALL abort the load: a return arriving in the cycle after rst is released SHALL be discarded with no *_we and no done.

Verification
REQ-034 Full load: base=0x0010, mask=3'b111, mem_gnt=1 constant -> grants at 0x10, 0x11, 0x12 on consecutive cycles; gamma_low_we, gamma_high_we, beta_we each for one cycle on consecutive cycles with the matching data; done with beta_we; busy high 5 cycles.
REQ-035 Partial mask: mask=3'b100, base=0x0100 -> a single read at 0x0102; only beta_we pulses; the other strobes stay 0.
REQ-036 Backpressure: mem_gnt low for 3 cycles during RD_GH -> mem_addr held at base+1 with mem_re=1; no duplicate or missing strobes.
REQ-037 Wrap and empty: base=0xFFFF, mask=3'b111 -> addresses 0xFFFF, 0x0000, 0x0001; separately mask=0 -> done one cycle after busy rises, no mem_re.
REQ-038 Reset and re-start: rst asserted one cycle after the GL grant -> no *_we, no done, all outputs 0; start asserted while busy -> ignored.
